// File: rtl/mpt_pkg.sv
// Shared types for the MPT table memory: the response record carried through
// the latency pipeline and the default word geometry.
package mpt_pkg;

  localparam int MPT_MEM_BYTES_PER_WORD = 4;
  // Response payload is sized for the widest (rv64) build; narrower builds zero-extend.
  localparam int MPT_MEM_DATA_MAX = 64;

  typedef struct packed {
    logic                        valid;
    logic                        error;
    logic [MPT_MEM_DATA_MAX-1:0] rdata;
  } mpt_mem_rsp_t;

  localparam int MPT_MEM_RSP_W = $bits(mpt_mem_rsp_t);

endpackage

// File: rtl/mpt_mem_rsp_pipe.sv
// LATENCY-deep shift register of response records; stage 0 is loaded on
// acceptance, the last stage drives the response port. Async clear drops in-flight entries.
module mpt_mem_rsp_pipe
  import mpt_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load,
  input  logic [MPT_MEM_RSP_W-1:0] rsp_in,
  output logic [MPT_MEM_RSP_W-1:0] rsp_out
);

  mpt_mem_rsp_t stage [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= load ? mpt_mem_rsp_t'(rsp_in) : '0;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign rsp_out = stage[LATENCY-1];

endmodule

// File: rtl/mpt_table_mem.sv
// Word-addressed, byte-writable table store on the req/gnt memory port with
// fixed-latency in-order responses; grants are limited by stall_i and an outstanding counter.
module mpt_table_mem
  import mpt_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = MPT_MEM_BYTES_PER_WORD * 8,
  parameter int                    DEPTH_WORDS     = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                    LATENCY         = 2,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    stall_i,
  input  logic                    s_mem_req,
  output logic                    s_mem_gnt,
  input  logic [ADDR_WIDTH-1:0]   s_mem_addr,
  input  logic                    s_mem_we,
  input  logic [DATA_WIDTH/8-1:0] s_mem_be,
  input  logic [DATA_WIDTH-1:0]   s_mem_wdata,
  output logic                    s_mem_valid,
  output logic [DATA_WIDTH-1:0]   s_mem_rdata,
  output logic                    s_mem_error
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BPW);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH:0] LIMIT =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(DEPTH_WORDS * BPW);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [CNT_W-1:0]      outstanding;
  logic                  accept;
  logic                  addr_err;
  logic [ADDR_WIDTH:0]   diff;
  logic [IDX_W-1:0]      idx;
  mpt_mem_rsp_t          rsp_in;
  mpt_mem_rsp_t          rsp_out;
  logic                  unused_rsp;

  // Registered count only: a response retiring this cycle does not reopen the grant.
  assign s_mem_gnt = rst_ni && !stall_i && (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign accept    = s_mem_req && s_mem_gnt;

  // One extra bit so that addresses below the base show up as a borrow.
  assign diff     = {1'b0, s_mem_addr} - {1'b0, BASE_ADDR};
  assign idx      = IDX_W'(diff >> OFF_W);
  assign addr_err = diff[ADDR_WIDTH] ||
                    ({1'b0, s_mem_addr} >= LIMIT) ||
                    (s_mem_addr[OFF_W-1:0] != '0);

  always_ff @(posedge clk_i) begin
    if (accept && s_mem_we && !addr_err) begin
      for (int b = 0; b < BPW; b++) begin
        if (s_mem_be[b]) mem[idx][b*8 +: 8] <= s_mem_wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = 1'b1;
    rsp_in.error = addr_err;
    if (!addr_err && !s_mem_we) rsp_in.rdata = MPT_MEM_DATA_MAX'(mem[idx]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else if (accept && !s_mem_valid) begin
      outstanding <= outstanding + 1'b1;
    end else if (!accept && s_mem_valid) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  mpt_mem_rsp_pipe #(
    .LATENCY (LATENCY)
  ) u_rsp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load    (accept),
    .rsp_in  (rsp_in),
    .rsp_out (rsp_out)
  );

  assign s_mem_valid = rsp_out.valid;
  assign s_mem_error = rsp_out.error;
  assign s_mem_rdata = rsp_out.rdata[DATA_WIDTH-1:0];
  assign unused_rsp  = ^rsp_out;

endmodule

// File: tb/tb_mpt_table_mem.sv
// Bench for mpt_table_mem: two instances (MAX_OUTSTANDING 2 and 1) share stimulus,
// each followed cycle by cycle by a queue-based reference model.
module tb_mpt_table_mem;

  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h1000;
  localparam int          DEPTH = 1024;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mask;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stall = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;

  logic        gnt_o [2];
  logic        vld_o [2];
  logic        err_o [2];
  logic [31:0] rd_o  [2];

  always #5 clk = ~clk;

  mpt_table_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
    .LATENCY(LAT), .MAX_OUTSTANDING(2)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall), .s_mem_req(req), .s_mem_gnt(gnt_o[0]),
    .s_mem_addr(addr), .s_mem_we(we), .s_mem_be(be), .s_mem_wdata(wdata),
    .s_mem_valid(vld_o[0]), .s_mem_rdata(rd_o[0]), .s_mem_error(err_o[0])
  );

  mpt_table_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
    .LATENCY(LAT), .MAX_OUTSTANDING(1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall), .s_mem_req(req), .s_mem_gnt(gnt_o[1]),
    .s_mem_addr(addr), .s_mem_we(we), .s_mem_be(be), .s_mem_wdata(wdata),
    .s_mem_valid(vld_o[1]), .s_mem_rdata(rd_o[1]), .s_mem_error(err_o[1])
  );

  exp_t        q  [2][$];
  logic [31:0] mm [2][8];
  logic [31:0] km [2][8];
  int          n = 0;
  int          total = 0;
  int          bad = 0;
  logic        dacc [2];
  logic        dv   [2];
  logic        derr [2];
  logic [31:0] drd  [2];

  function automatic int mo(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, n);
    end
  endtask

  // Inputs are already driven for interval n; compare at the falling edge, then step the model.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic g;
      exp_t e;
      int   w;
      dacc[i] = rst_ni && req && gnt_o[i];
      dv[i]   = vld_o[i];
      derr[i] = err_o[i];
      drd[i]  = rd_o[i];
      if (!rst_ni) q[i].delete();
      g = rst_ni && !stall && (q[i].size() < mo(i));
      check($sformatf("gnt%0d", i), 32'(gnt_o[i]), 32'(g));
      if (!rst_ni) begin
        check($sformatf("rst_vld%0d", i), 32'(vld_o[i]), 0);
        check($sformatf("rst_rdata%0d", i), rd_o[i], 0);
        check($sformatf("rst_err%0d", i), 32'(err_o[i]), 0);
      end else if (q[i].size() > 0 && q[i][0].due == n) begin
        e = q[i].pop_front();
        check($sformatf("vld%0d", i), 32'(vld_o[i]), 1);
        check($sformatf("err%0d", i), 32'(err_o[i]), 32'(e.err));
        if (e.mask != 0)
          check($sformatf("rdata%0d", i), rd_o[i] & e.mask, e.rdata & e.mask);
      end else begin
        check($sformatf("idle_vld%0d", i), 32'(vld_o[i]), 0);
      end
      if (req && g) begin
        e.due   = n + LAT;
        e.err   = (addr < BASE) || (addr >= BASE + DEPTH * 4) || (addr[1:0] != 2'b00);
        e.rdata = '0;
        e.mask  = 32'hFFFF_FFFF;
        w       = int'((addr - BASE) >> 2);
        if (!e.err && w < 8) begin
          if (we) begin
            for (int b = 0; b < 4; b++) begin
              if (be[b]) begin
                mm[i][w][8*b +: 8] = wdata[8*b +: 8];
                km[i][w][8*b +: 8] = 8'hFF;
              end
            end
          end else begin
            e.rdata = mm[i][w];
            e.mask  = km[i][w];
          end
        end else if (!e.err && !we) begin
          e.mask = '0;
        end
        q[i].push_back(e);
      end
    end
    @(posedge clk);
    n++;
    #1;
  endtask

  task automatic idle(input int cycles);
    req = 1'b0;
    for (int k = 0; k < cycles; k++) tick();
  endtask

  task automatic txn(input vec_t v, input string nm);
    int an;
    bit got;
    req = 1'b1; we = v.we; addr = v.addr; be = v.be; wdata = v.wdata;
    got = 1'b0;
    an  = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (dacc[0]) begin got = 1'b1; an = n - 1; end
    end
    req = 1'b0;
    if (!got) begin
      check({nm, "_gnt_timeout"}, 0, 1);
      return;
    end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (dv[0]) begin
        got = 1'b1;
        check({nm, "_latency"}, 32'(n - 1 - an), LAT);
        check({nm, "_error"}, 32'(derr[0]), 32'(v.exp_err));
        check({nm, "_rdata"}, drd[0], v.exp_rdata);
      end
    end
    if (!got) check({nm, "_rsp_timeout"}, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [15];
    int   cnt;
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 8; w++) begin mm[i][w] = '0; km[i][w] = '0; end

    tbl[0]  = '{1'b1, 32'h1010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h1010, 4'h0, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h1014, 4'hF, 32'h11223344, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'h1014, 4'h2, 32'h0000AB00, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h1014, 4'h0, 32'h0,        1'b0, 32'h1122AB44};
    tbl[5]  = '{1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h0FFC, 4'h0, 32'h0,        1'b1, 32'h0};
    tbl[7]  = '{1'b0, 32'h2000, 4'h0, 32'h0,        1'b1, 32'h0};
    tbl[8]  = '{1'b0, 32'h1002, 4'h0, 32'h0,        1'b1, 32'h0};
    tbl[9]  = '{1'b1, 32'h1001, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 32'h1000, 4'h0, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[11] = '{1'b1, 32'h1000, 4'h0, 32'h55555555, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 32'h1000, 4'h0, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[13] = '{1'b1, 32'h1FFC, 4'hF, 32'hA5A5A5A5, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 32'h1FFC, 4'h0, 32'h0,        1'b0, 32'hA5A5A5A5};

    rst_ni = 1'b0;
    #1;
    idle(3);
    rst_ni = 1'b1;
    idle(2);

    for (int t = 0; t < 15; t++) txn(tbl[t], $sformatf("vec%0d", t));

    // Held reads into the MAX_OUTSTANDING=1 instance: accepts every third cycle.
    idle(4);
    req = 1'b1; we = 1'b0; addr = 32'h1010;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin tick(); if (dacc[1]) cnt++; end
    check("mo1_accepts", cnt, 4);

    // Stall with a response in flight and the request held.
    idle(4);
    req = 1'b1; we = 1'b0; addr = 32'h1014;
    tick();
    check("pre_stall_acc", 32'(dacc[0]), 1);
    stall = 1'b1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin tick(); if (dacc[0]) cnt++; end
    check("stall_no_acc", cnt, 0);
    stall = 1'b0;
    tick();
    check("stall_release_acc", 32'(dacc[0]), 1);
    idle(4);

    // Reset one cycle after an accepted read: its response must never appear.
    req = 1'b1; we = 1'b0; addr = 32'h1010;
    tick();
    check("pre_reset_acc", 32'(dacc[0]), 1);
    req = 1'b0;
    rst_ni = 1'b0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin tick(); if (dv[0] || dv[1]) cnt++; end
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin tick(); if (dv[0] || dv[1]) cnt++; end
    check("reset_dropped", cnt, 0);
    txn(tbl[1], "post_reset_read");

    idle(4);
    for (int k = 0; k < 400; k++) begin
      int sel;
      sel   = $urandom_range(0, 10);
      stall = ($urandom_range(0, 9) == 0);
      req   = ($urandom_range(0, 9) < 6);
      we    = $urandom_range(0, 1) == 1;
      be    = 4'($urandom_range(0, 15));
      wdata = $urandom;
      case (sel)
        8:       addr = BASE - 32'd4;
        9:       addr = BASE + DEPTH * 4;
        10:      addr = BASE + 32'($urandom_range(0, 7)) * 4 + 32'd2;
        default: addr = BASE + 32'(sel) * 4;
      endcase
      tick();
    end
    stall = 1'b0;
    idle(6);
    check("drain_empty", 32'(q[0].size() + q[1].size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
